shift_reg_tx: RTL and testbench

//   Parameterized parallel-to-serial transmitter: the sending end of a

---
 rtl/shift_reg_tx.sv | 83 ++++++++
 tb/tb_shift_reg_tx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_tx.sv
// Parallel-to-serial transmitter: one WIDTH-bit word per load handshake, sent one bit per beat.
// Optional even-parity beat appended when SHIFT_REG_TX_PARITY_EN is defined.
module shift_reg_tx #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_data,
  output logic             ser_last,
  output logic             busy
);

`ifdef SHIFT_REG_TX_PARITY_EN
  localparam int unsigned NBITS = WIDTH + 1;
`else
  localparam int unsigned NBITS = WIDTH;
`endif
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [NBITS-1:0] shreg, shreg_nxt, load_word;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             beat, last, load_take;

  // Parity sits at the far end of the register so it leaves after the data bits.
  always_comb begin
`ifdef SHIFT_REG_TX_PARITY_EN
    load_word = MSB_FIRST ? {load_data, ^load_data} : {^load_data, load_data};
`else
    load_word = load_data;
`endif
  end

  assign ser_valid  = (state == SHIFT);
  assign busy       = (state == SHIFT);
  assign last       = (state == SHIFT) && (cnt == CW'(NBITS - 1));
  assign ser_last   = last;
  assign ser_data   = MSB_FIRST ? shreg[NBITS-1] : shreg[0];
  assign beat       = ser_valid & ser_ready;
  assign load_ready = (state == IDLE) | (beat & last);
  assign load_take  = load_valid & load_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A load accepted on the final beat takes priority over the shift, giving gapless words.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    if (load_take) begin
      state_nxt = SHIFT;
      shreg_nxt = load_word;
      cnt_nxt   = '0;
    end else if (beat) begin
      shreg_nxt = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
      if (last) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_shift_reg_tx.sv
// Scoreboard bench for shift_reg_tx: MSB-first and LSB-first instances, expected beats queued at load.
// Define SHIFT_REG_TX_PARITY_EN for both RTL and bench to exercise the parity beat.
module tb_shift_reg_tx;
  localparam int W = 8;
`ifdef SHIFT_REG_TX_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  typedef struct packed {logic d; logic l;} beat_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load_valid, load_ready, ser_valid, ser_ready, ser_data, ser_last, busy;
  logic [W-1:0] load_data;
  logic         l_load_valid, l_load_ready, l_ser_valid, l_ser_ready, l_ser_data, l_ser_last, l_busy;
  logic [W-1:0] l_load_data;

  int    n_checks = 0;
  int    n_errors = 0;
  beat_t q_m[$];
  beat_t q_l[$];

  always #5 clk = ~clk;

  shift_reg_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .ser_valid(ser_valid), .ser_ready(ser_ready),
    .ser_data(ser_data), .ser_last(ser_last), .busy(busy)
  );

  shift_reg_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .load_valid(l_load_valid), .load_ready(l_load_ready),
    .load_data(l_load_data), .ser_valid(l_ser_valid), .ser_ready(l_ser_ready),
    .ser_data(l_ser_data), .ser_last(l_ser_last), .busy(l_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_bit(input logic [W-1:0] w, input int i, input bit msb);
    if (i == W) return ^w;
    return msb ? w[W-1-i] : w[i];
  endfunction

  always @(negedge clk) begin
    logic  exp_lr;
    beat_t e;
    if (!rst_n) begin
      q_m.delete();
      check("rst_valid", 32'(ser_valid), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_load_ready", 32'(load_ready), 1);
    end else begin
      check("valid", 32'(ser_valid), 32'(q_m.size() != 0));
      check("busy", 32'(busy), 32'(q_m.size() != 0));
      exp_lr = (q_m.size() == 0) || (ser_ready && q_m[0].l);
      check("load_ready", 32'(load_ready), 32'(exp_lr));
      if (q_m.size() != 0) begin
        check("data", 32'(ser_data), 32'(q_m[0].d));
        check("last", 32'(ser_last), 32'(q_m[0].l));
        if (ser_ready) void'(q_m.pop_front());
      end
      if (load_valid && exp_lr)
        for (int i = 0; i < NB; i++) begin
          e.d = exp_bit(load_data, i, 1'b1);
          e.l = (i == NB - 1);
          q_m.push_back(e);
        end
    end
  end

  always @(negedge clk) begin
    logic  exp_lr;
    beat_t e;
    if (!rst_n) begin
      q_l.delete();
    end else begin
      check("l_valid", 32'(l_ser_valid), 32'(q_l.size() != 0));
      check("l_busy", 32'(l_busy), 32'(q_l.size() != 0));
      exp_lr = (q_l.size() == 0) || (l_ser_ready && q_l[0].l);
      check("l_load_ready", 32'(l_load_ready), 32'(exp_lr));
      if (q_l.size() != 0) begin
        check("l_data", 32'(l_ser_data), 32'(q_l[0].d));
        check("l_last", 32'(l_ser_last), 32'(q_l[0].l));
        if (l_ser_ready) void'(q_l.pop_front());
      end
      if (l_load_valid && exp_lr)
        for (int i = 0; i < NB; i++) begin
          e.d = exp_bit(l_load_data, i, 1'b0);
          e.l = (i == NB - 1);
          q_l.push_back(e);
        end
    end
  end

  task automatic send(input logic [W-1:0] w);
    bit ok = 1'b0;
    load_valid = 1'b1;
    load_data  = w;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (load_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("load_timeout", 0, 1);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    load_data  = W'($urandom);
  endtask

  task automatic send_l(input logic [W-1:0] w);
    bit ok = 1'b0;
    l_load_valid = 1'b1;
    l_load_data  = w;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      if (l_load_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("l_load_timeout", 0, 1);
    @(posedge clk);
    #1;
    l_load_valid = 1'b0;
    l_load_data  = W'($urandom);
  endtask

  task automatic drain(input bit lsb);
    bit ok = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (!(lsb ? l_busy : busy)) begin ok = 1'b1; break; end
    end
    if (!ok) check("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst_n        = 1'b0;
    load_valid   = 1'b0;
    load_data    = '0;
    ser_ready    = 1'b1;
    l_load_valid = 1'b0;
    l_load_data  = '0;
    l_ser_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    send(8'hA5);
    drain(1'b0);

    send_l(8'h01);
    drain(1'b1);

    send(8'hC3);
    repeat (3) @(posedge clk);
    #1 ser_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 ser_ready = 1'b1;
    drain(1'b0);

    send(8'hF0);
    send(8'h0F);
    drain(1'b0);

    send(8'hFF);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(8'h5A);
    drain(1'b0);

`ifdef SHIFT_REG_TX_PARITY_EN
    send(8'h07);
    drain(1'b0);
`endif

    fork
      for (int k = 0; k < 6; k++) send(W'($urandom));
      begin
        repeat (120) begin
          @(posedge clk);
          #1 ser_ready = 1'($urandom_range(0, 1));
        end
        ser_ready = 1'b1;
      end
    join
    ser_ready = 1'b1;
    drain(1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
